// File: rtl/bus_arbiter.sv
// Shares one RAM port between the icache and dcache of CPUS cores: data before instruction,
// round-robin within each class, and a short hold after a dcache word so 2-word blocks stay together.
module bus_arbiter #(
  parameter int CPUS        = 2,
  parameter int LOCK_WINDOW = 2
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS*32-1:0]   iaddr,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS*32-1:0]   iload,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [CPUS*32-1:0]   daddr,
  input  logic [CPUS*32-1:0]   dstore,
  output logic [CPUS-1:0]      dwait,
  output logic [CPUS*32-1:0]   dload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  input  logic [31:0]          ramload,
  input  logic [1:0]           ramstate,
  output logic                 ram_err,
  output logic [1:0]           dbg_state
);
  localparam int CW  = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int LCW = $clog2(LOCK_WINDOW + 1);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, LOCK = 2'd2} state_t;

  // Handshake: a requester holds REN/WEN (and address/data) until its wait goes low;
  // wait low marks the single completing cycle of that word.
  state_t         state_q, state_d;
  logic           gnt_cls_q, gnt_cls_d;
  logic [CW-1:0]  gnt_core_q, gnt_core_d;
  logic [CW-1:0]  d_rr_q, d_rr_d, i_rr_q, i_rr_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           second_q, second_d;
  logic           ram_err_q, ram_err_d;

  logic [CPUS-1:0] d_req;
  logic [CW:0]     d_pick, i_pick;
  logic            gnt_dreq, gnt_dwen, gnt_iren, gnt_req;
  logic [31:0]     gnt_iaddr, gnt_daddr, gnt_dstore;

  // Returns {found, index} of the first set request at or after rr, wrapping mod CPUS.
  function automatic logic [CW:0] rr_pick(input logic [CPUS-1:0] req, input logic [CW-1:0] rr);
    logic [CW:0] res;
    int idx;
    res = '0;
    for (int k = CPUS - 1; k >= 0; k--) begin
      idx = (int'(rr) + k) % CPUS;
      if (req[idx]) res = {1'b1, CW'(idx)};
    end
    return res;
  endfunction

  function automatic logic [CW-1:0] rr_next(input logic [CW-1:0] p);
    return (int'(p) == CPUS - 1) ? '0 : p + 1'b1;
  endfunction

  assign d_req     = dREN | dWEN;
  assign ram_err   = ram_err_q;
  assign dbg_state = state_q;

  always_comb begin
    gnt_dreq   = 1'b0;
    gnt_dwen   = 1'b0;
    gnt_iren   = 1'b0;
    gnt_iaddr  = '0;
    gnt_daddr  = '0;
    gnt_dstore = '0;
    for (int c = 0; c < CPUS; c++) begin
      if (gnt_core_q == CW'(c)) begin
        gnt_dreq   = d_req[c];
        gnt_dwen   = dWEN[c];
        gnt_iren   = iREN[c];
        gnt_iaddr  = iaddr[c*32 +: 32];
        gnt_daddr  = daddr[c*32 +: 32];
        gnt_dstore = dstore[c*32 +: 32];
      end
    end
    gnt_req = gnt_cls_q ? gnt_dreq : gnt_iren;
  end

  always_comb begin
    state_d    = state_q;
    gnt_cls_d  = gnt_cls_q;
    gnt_core_d = gnt_core_q;
    d_rr_d     = d_rr_q;
    i_rr_d     = i_rr_q;
    lock_cnt_d = lock_cnt_q;
    second_d   = second_q;
    ram_err_d  = ram_err_q;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = '1;
    dwait      = '1;
    iload      = '0;
    dload      = '0;
    d_pick     = rr_pick(d_req, d_rr_q);
    i_pick     = rr_pick(iREN, i_rr_q);

    case (state_q)
      IDLE: begin
        if (d_pick[CW]) begin
          gnt_cls_d  = 1'b1;
          gnt_core_d = d_pick[CW-1:0];
          d_rr_d     = rr_next(d_pick[CW-1:0]);
          state_d    = GRANT;
        end else if (i_pick[CW]) begin
          gnt_cls_d  = 1'b0;
          gnt_core_d = i_pick[CW-1:0];
          i_rr_d     = rr_next(i_pick[CW-1:0]);
          state_d    = GRANT;
        end
      end

      GRANT: begin
        for (int c = 0; c < CPUS; c++) begin
          if (gnt_core_q == CW'(c)) begin
            if (gnt_cls_q) dload[c*32 +: 32] = ramload;
            else           iload[c*32 +: 32] = ramload;
          end
        end
        if (ramstate == RAM_ERROR) ram_err_d = 1'b1;
        if (!gnt_req) begin
          state_d  = IDLE;
          second_d = 1'b0;
        end else begin
          if (gnt_cls_q) begin
            ramWEN   = gnt_dwen;
            ramREN   = !gnt_dwen;
            ramaddr  = gnt_daddr;
            ramstore = gnt_dstore;
          end else begin
            ramREN  = 1'b1;
            ramaddr = gnt_iaddr;
          end
          if (ramstate == RAM_ACCESS) begin
            if (gnt_cls_q) dwait[gnt_core_q] = 1'b0;
            else           iwait[gnt_core_q] = 1'b0;
            // First dcache word opens the hold window for the block's second word.
            if (gnt_cls_q && !second_q) begin
              state_d    = LOCK;
              lock_cnt_d = LCW'(LOCK_WINDOW);
              second_d   = 1'b1;
            end else begin
              state_d  = IDLE;
              second_d = 1'b0;
            end
          end
        end
      end

      LOCK: begin
        if (gnt_dreq) begin
          state_d = GRANT;
        end else if (lock_cnt_q <= LCW'(1)) begin
          state_d  = IDLE;
          second_d = 1'b0;
        end else begin
          lock_cnt_d = lock_cnt_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      gnt_cls_q  <= 1'b0;
      gnt_core_q <= '0;
      d_rr_q     <= '0;
      i_rr_q     <= '0;
      lock_cnt_q <= '0;
      second_q   <= 1'b0;
      ram_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_cls_q  <= gnt_cls_d;
      gnt_core_q <= gnt_core_d;
      d_rr_q     <= d_rr_d;
      i_rr_q     <= i_rr_d;
      lock_cnt_q <= lock_cnt_d;
      second_q   <= second_d;
      ram_err_q  <= ram_err_d;
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed vector table, hand-written corner sequences and random
// traffic, all scored against a transaction-level model of the arbitration rules.
module tb_bus_arbiter;
  localparam int CPUS = 2;
  localparam int LW   = 2;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

  logic                CLK = 1'b0;
  logic                nRST;
  logic [CPUS-1:0]     iREN, dREN, dWEN, iwait, dwait;
  logic [CPUS*32-1:0]  iaddr, daddr, dstore, iload, dload;
  logic                ramREN, ramWEN, ram_err;
  logic [31:0]         ramaddr, ramstore, ramload;
  logic [1:0]          ramstate, dbg_state;

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  bus_arbiter #(.CPUS(CPUS), .LOCK_WINDOW(LW)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err), .dbg_state(dbg_state)
  );

  typedef struct packed {
    logic [CPUS-1:0]    iwait;
    logic [CPUS-1:0]    dwait;
    logic               ren;
    logic               wen;
    logic [31:0]        addr;
    logic [31:0]        store;
    logic               err;
    logic [CPUS*32-1:0] iload;
    logic [CPUS*32-1:0] dload;
  } obs_t;
  localparam int OW = $bits(obs_t);

  typedef struct {
    logic [1:0]  iren, dren, dwen, rs;
    logic [31:0] a0;
    logic [1:0]  e_iw, e_dw;
    logic        e_ren, e_wen;
    logic [31:0] e_addr;
  } vec_t;

  vec_t         tbl[$];
  logic [OW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // Owner id: data requesters are CPUS+core, instruction requesters are core; -1 means none.
  int m_owner, m_hold_until, m_dnext, m_inext, m_cycle;
  bit m_drive, m_in_block, m_err;

  function automatic void model_reset();
    m_owner = -1; m_drive = 0; m_in_block = 0; m_err = 0;
    m_hold_until = 0; m_dnext = 0; m_inext = 0; m_cycle = 0;
  endfunction

  function automatic int first_from(logic [CPUS-1:0] req, int start);
    for (int k = 0; k < CPUS; k++)
      if (req[(start + k) % CPUS]) return (start + k) % CPUS;
    return -1;
  endfunction

  function automatic bit owner_req();
    int core = m_owner % CPUS;
    if (m_owner >= CPUS) return dREN[core] | dWEN[core];
    return iREN[core];
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    int core;
    o = '0;
    o.iwait = '1;
    o.dwait = '1;
    o.err = m_err;
    if (m_owner >= 0 && m_drive) begin
      core = m_owner % CPUS;
      if (m_owner >= CPUS) o.dload[core*32 +: 32] = ramload;
      else                 o.iload[core*32 +: 32] = ramload;
      if (owner_req()) begin
        if (m_owner >= CPUS) begin
          if (dWEN[core]) o.wen = 1'b1; else o.ren = 1'b1;
          o.addr  = daddr[core*32 +: 32];
          o.store = dstore[core*32 +: 32];
        end else begin
          o.ren  = 1'b1;
          o.addr = iaddr[core*32 +: 32];
        end
        if (ramstate == ACC) begin
          if (m_owner >= CPUS) o.dwait[core] = 1'b0; else o.iwait[core] = 1'b0;
        end
      end
    end
    return o;
  endfunction

  function automatic void model_step();
    int w;
    if (m_owner >= 0 && m_drive) begin
      if (ramstate == ERR) m_err = 1;
      if (!owner_req()) begin
        m_owner = -1; m_drive = 0; m_in_block = 0;
      end else if (ramstate == ACC) begin
        if (m_owner >= CPUS && !m_in_block) begin
          m_in_block = 1; m_drive = 0; m_hold_until = m_cycle + LW;
        end else begin
          m_owner = -1; m_drive = 0; m_in_block = 0;
        end
      end
    end else if (m_owner >= 0) begin
      if (owner_req()) m_drive = 1;
      else if (m_cycle >= m_hold_until) begin
        m_owner = -1; m_in_block = 0;
      end
    end else begin
      w = first_from(dREN | dWEN, m_dnext);
      if (w >= 0) begin
        m_owner = CPUS + w; m_dnext = (w + 1) % CPUS; m_drive = 1;
      end else begin
        w = first_from(iREN, m_inext);
        if (w >= 0) begin
          m_owner = w; m_inext = (w + 1) % CPUS; m_drive = 1;
        end
      end
    end
    m_cycle++;
  endfunction

  // ---------------- scoreboard / checks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sample(input string name);
    obs_t a;
    logic [OW-1:0] e;
    @(negedge CLK);
    exp_q.push_back(model_out());
    a = '{iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, ram_err, iload, dload};
    e = exp_q.pop_front();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL model_%s @%0t: got %0h expected %0h", name, $time, a, e);
    end
    model_step();
  endtask

  task automatic advance();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0; ramstate = FREE;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    clear_inputs();
    @(posedge CLK);
    #1;
    check("rst_waits", {iwait, dwait}, {2*CPUS{1'b1}});
    check("rst_ram", {ramREN, ramWEN, ramaddr, ramstore}, 64'h0);
    check("rst_err_state", {ram_err, dbg_state}, 3'b000);
    @(negedge CLK);
    nRST = 1'b1;
    model_reset();
    advance();
  endtask

  task automatic set_fixed_data();
    iaddr   = {32'h0000_0080, 32'h0000_0040};
    daddr   = {32'h0000_0200, 32'h0000_0100};
    dstore  = {32'hBBBB_0000, 32'hAAAA_0000};
    ramload = 32'h1234_5678;
  endtask

  function automatic vec_t v(logic [1:0] ir, logic [1:0] dr, logic [1:0] dw, logic [1:0] rs,
                             logic [31:0] a0, logic [1:0] eiw, logic [1:0] edw,
                             logic er, logic ew, logic [31:0] ea);
    vec_t r;
    r.iren = ir; r.dren = dr; r.dwen = dw; r.rs = rs; r.a0 = a0;
    r.e_iw = eiw; r.e_dw = edw; r.e_ren = er; r.e_wen = ew; r.e_addr = ea;
    return r;
  endfunction

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    vec_t t;
    logic [1:0] rsel;
    nRST = 1'b0;
    set_fixed_data();
    clear_inputs();

    // Single instruction fetch, instruction vs data race, continuous data from both cores,
    // and a write block re-granted inside the hold window despite a competing core.
    tbl.push_back(v(2'b01, 2'b00, 2'b00, FREE, 32'h100, 2'b11, 2'b11, 0, 0, 32'h0));
    tbl.push_back(v(2'b01, 2'b00, 2'b00, BUSY, 32'h100, 2'b11, 2'b11, 1, 0, 32'h40));
    tbl.push_back(v(2'b01, 2'b00, 2'b00, BUSY, 32'h100, 2'b11, 2'b11, 1, 0, 32'h40));
    tbl.push_back(v(2'b01, 2'b00, 2'b00, ACC,  32'h100, 2'b10, 2'b11, 1, 0, 32'h40));
    tbl.push_back(v(2'b00, 2'b00, 2'b00, FREE, 32'h100, 2'b11, 2'b11, 0, 0, 32'h0));
    tbl.push_back(v(2'b01, 2'b10, 2'b00, FREE, 32'h100, 2'b11, 2'b11, 0, 0, 32'h0));
    tbl.push_back(v(2'b01, 2'b10, 2'b00, ACC,  32'h100, 2'b11, 2'b01, 1, 0, 32'h200));
    tbl.push_back(v(2'b01, 2'b00, 2'b00, FREE, 32'h100, 2'b11, 2'b11, 0, 0, 32'h0));
    tbl.push_back(v(2'b01, 2'b00, 2'b00, FREE, 32'h100, 2'b11, 2'b11, 0, 0, 32'h0));
    tbl.push_back(v(2'b01, 2'b00, 2'b00, FREE, 32'h100, 2'b11, 2'b11, 0, 0, 32'h0));
    tbl.push_back(v(2'b01, 2'b00, 2'b00, ACC,  32'h100, 2'b10, 2'b11, 1, 0, 32'h40));
    tbl.push_back(v(2'b00, 2'b00, 2'b00, FREE, 32'h100, 2'b11, 2'b11, 0, 0, 32'h0));
    tbl.push_back(v(2'b00, 2'b11, 2'b00, FREE, 32'h100, 2'b11, 2'b11, 0, 0, 32'h0));
    tbl.push_back(v(2'b00, 2'b11, 2'b00, ACC,  32'h100, 2'b11, 2'b10, 1, 0, 32'h100));
    tbl.push_back(v(2'b00, 2'b11, 2'b00, ACC,  32'h100, 2'b11, 2'b11, 0, 0, 32'h0));
    tbl.push_back(v(2'b00, 2'b11, 2'b00, ACC,  32'h100, 2'b11, 2'b10, 1, 0, 32'h100));
    tbl.push_back(v(2'b00, 2'b11, 2'b00, ACC,  32'h100, 2'b11, 2'b11, 0, 0, 32'h0));
    tbl.push_back(v(2'b00, 2'b11, 2'b00, ACC,  32'h100, 2'b11, 2'b01, 1, 0, 32'h200));
    tbl.push_back(v(2'b00, 2'b11, 2'b00, ACC,  32'h100, 2'b11, 2'b11, 0, 0, 32'h0));
    tbl.push_back(v(2'b00, 2'b11, 2'b00, ACC,  32'h100, 2'b11, 2'b01, 1, 0, 32'h200));
    tbl.push_back(v(2'b00, 2'b11, 2'b00, ACC,  32'h100, 2'b11, 2'b11, 0, 0, 32'h0));
    tbl.push_back(v(2'b00, 2'b11, 2'b00, ACC,  32'h100, 2'b11, 2'b10, 1, 0, 32'h100));
    tbl.push_back(v(2'b00, 2'b00, 2'b00, FREE, 32'h100, 2'b11, 2'b11, 0, 0, 32'h0));
    tbl.push_back(v(2'b00, 2'b00, 2'b00, FREE, 32'h100, 2'b11, 2'b11, 0, 0, 32'h0));
    tbl.push_back(v(2'b00, 2'b00, 2'b00, FREE, 32'h100, 2'b11, 2'b11, 0, 0, 32'h0));
    tbl.push_back(v(2'b00, 2'b00, 2'b01, FREE, 32'h100, 2'b11, 2'b11, 0, 0, 32'h0));
    tbl.push_back(v(2'b00, 2'b00, 2'b01, ACC,  32'h100, 2'b11, 2'b10, 0, 1, 32'h100));
    tbl.push_back(v(2'b00, 2'b10, 2'b00, FREE, 32'h100, 2'b11, 2'b11, 0, 0, 32'h0));
    tbl.push_back(v(2'b00, 2'b10, 2'b01, FREE, 32'h104, 2'b11, 2'b11, 0, 0, 32'h0));
    tbl.push_back(v(2'b00, 2'b10, 2'b01, ACC,  32'h104, 2'b11, 2'b10, 0, 1, 32'h104));
    tbl.push_back(v(2'b00, 2'b10, 2'b00, FREE, 32'h100, 2'b11, 2'b11, 0, 0, 32'h0));
    tbl.push_back(v(2'b00, 2'b10, 2'b00, ACC,  32'h100, 2'b11, 2'b01, 1, 0, 32'h200));
    tbl.push_back(v(2'b00, 2'b00, 2'b00, FREE, 32'h100, 2'b11, 2'b11, 0, 0, 32'h0));
    tbl.push_back(v(2'b00, 2'b00, 2'b00, FREE, 32'h100, 2'b11, 2'b11, 0, 0, 32'h0));
    tbl.push_back(v(2'b00, 2'b00, 2'b00, FREE, 32'h100, 2'b11, 2'b11, 0, 0, 32'h0));

    do_reset();
    for (int r = 0; r < tbl.size(); r++) begin
      t = tbl[r];
      iREN = t.iren; dREN = t.dren; dWEN = t.dwen; ramstate = t.rs;
      daddr[31:0] = t.a0;
      sample("table");
      check($sformatf("row%0d", r), {iwait, dwait, ramREN, ramWEN, ramaddr},
            {t.e_iw, t.e_dw, t.e_ren, t.e_wen, t.e_addr});
      advance();
    end

    // RAM error during a dcache grant: wait held, sticky flag, then completion.
    set_fixed_data();
    do_reset();
    dREN = 2'b01; ramstate = FREE;
    sample("err"); advance();
    for (int k = 0; k < 3; k++) begin
      ramstate = ERR;
      sample("err");
      check("err_dwait", {dwait, ramREN, ramaddr}, {2'b11, 1'b1, 32'h100});
      check("err_flag", ram_err, (k > 0) ? 64'd1 : 64'd0);
      advance();
    end
    ramstate = ACC;
    sample("err");
    check("err_done", {dwait, ram_err}, 3'b101);
    check("err_dload", dload, {32'h0, 32'h1234_5678});
    advance();
    dREN = 2'b00; ramstate = FREE;
    for (int k = 0; k < 4; k++) begin
      sample("err"); advance();
    end
    check("err_sticky", ram_err, 64'd1);

    // Reset asserted while a grant is active; pointer must restart at core 0.
    do_reset();
    dREN = 2'b01; ramstate = BUSY;
    sample("rst"); advance();
    sample("rst");
    check("rst_pre_grant", {ramREN, dwait}, 3'b111);
    #1 nRST = 1'b0;
    #1;
    check("rst_async_ram", {ramREN, ramWEN, iwait, dwait}, 6'b001111);
    check("rst_async_state", {dbg_state, ram_err}, 3'b000);
    do_reset();
    dREN = 2'b11; ramstate = ACC;
    sample("rst"); advance();
    sample("rst");
    check("rst_rr_restart", {dwait, ramaddr}, {2'b10, 32'h100});
    advance();

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      if ($urandom_range(0, 3) == 0) begin
        iREN = CPUS'($urandom_range(0, 3));
        dREN = CPUS'($urandom_range(0, 3));
        dWEN = CPUS'($urandom_range(0, 3) & $urandom_range(0, 3));
      end
      rsel = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:             ramstate = FREE;
        1, 2, 3:       ramstate = BUSY;
        9:             ramstate = ERR;
        default:       ramstate = ACC;
      endcase
      if (rsel == 2'd0) begin
        iaddr  = {$urandom, $urandom};
        daddr  = {$urandom, $urandom};
        dstore = {$urandom, $urandom};
      end
      ramload = $urandom;
      sample("rand");
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
